// File: rtl/hs_error_arbiter.sv
// Two-channel 4-phase arbiter sharing one error-detecting stage.
// Grants, strobes the stage, re-samples on timing errors, forwards downstream.
//
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   Lreq0 / Lack0    : channel-0 upstream 4-phase handshake
//   Lreq1 / Lack1    : channel-1 upstream 4-phase handshake
//   Rreq / Rack      : downstream 4-phase handshake
//   sel              : stage input-mux select (0 = ch0, 1 = ch1)
//   sample           : one-cycle latch strobe for stage + shadow register
//   Err              : stage error flag (async, synchronized here)
//   retry_cnt        : re-samples taken in the current transaction
//   err_fatal        : sticky flag, a transaction ran out of retries
module hs_error_arbiter #(
  parameter int SETUP_CYCLES = 2,
  parameter int ERR_WAIT     = 4,
  parameter int MAX_RETRY    = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             Lreq0,
  output logic                             Lack0,
  input  logic                             Lreq1,
  output logic                             Lack1,
  output logic                             Rreq,
  input  logic                             Rack,
  output logic                             sel,
  output logic                             sample,
  input  logic                             Err,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
  output logic                             err_fatal
);

  localparam int CMAX =
    (SETUP_CYCLES > ERR_WAIT) ? SETUP_CYCLES : ERR_WAIT;
  localparam int CW = $clog2(CMAX + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(ERR_WAIT - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SAMPLE,
    S_ERRWAIT,
    S_REQ,
    S_ACK,
    S_RTZ
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [RW-1:0]   r_retry;
  logic            r_prio;
  logic            r_sel;
  logic            r_sample;
  logic            r_rreq;
  logic            r_lack0;
  logic            r_lack1;
  logic            r_fatal;

  logic [1:0]      r_lreq0_sync;
  logic [1:0]      r_lreq1_sync;
  logic [1:0]      r_rack_sync;
  logic [1:0]      r_err_sync;

  logic            w_lreq0;
  logic            w_lreq1;
  logic            w_rack;
  logic            w_err;
  logic            w_any;
  logic            w_win;
  logic            w_lreq_g;

  // Two-flop synchronizers on every asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lreq0_sync <= '0;
      r_lreq1_sync <= '0;
      r_rack_sync  <= '0;
      r_err_sync   <= '0;
    end else begin
      r_lreq0_sync <= {r_lreq0_sync[0], Lreq0};
      r_lreq1_sync <= {r_lreq1_sync[0], Lreq1};
      r_rack_sync  <= {r_rack_sync[0], Rack};
      r_err_sync   <= {r_err_sync[0], Err};
    end
  end

  assign w_lreq0 = r_lreq0_sync[1];
  assign w_lreq1 = r_lreq1_sync[1];
  assign w_rack  = r_rack_sync[1];
  assign w_err   = r_err_sync[1];

  assign w_any = w_lreq0 | w_lreq1;

  // Contention goes to prio; otherwise the lone requester wins.
  assign w_win = (w_lreq0 & w_lreq1) ? r_prio : w_lreq1;

  // Return-to-zero is watched on the granted channel only.
  assign w_lreq_g = r_sel ? w_lreq1 : w_lreq0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_retry  <= '0;
      r_prio   <= 1'b0;
      r_sel    <= 1'b0;
      r_sample <= 1'b0;
      r_rreq   <= 1'b0;
      r_lack0  <= 1'b0;
      r_lack1  <= 1'b0;
      r_fatal  <= 1'b0;
    end else begin
      r_sample <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel   <= w_win;
            r_retry <= '0;
            r_cnt   <= '0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_cnt    <= '0;
            r_sample <= 1'b1;
            r_state  <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          r_cnt   <= '0;
          r_state <= S_ERRWAIT;
        end
        S_ERRWAIT: begin
          // Err is judged on the final window cycle only.
          if (r_cnt == WAIT_LAST) begin
            r_cnt <= '0;
            if (!w_err) begin
              r_rreq  <= 1'b1;
              r_state <= S_REQ;
            end else if (r_retry < RETRY_MAX) begin
              r_retry <= r_retry + 1'b1;
              r_state <= S_SETUP;
            end else begin
              // Out of retries: forward anyway, flag it.
              r_fatal <= 1'b1;
              r_rreq  <= 1'b1;
              r_state <= S_REQ;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_REQ: begin
          if (w_rack) begin
            r_lack0 <= ~r_sel;
            r_lack1 <= r_sel;
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          if (!w_lreq_g) begin
            r_rreq  <= 1'b0;
            r_state <= S_RTZ;
          end
        end
        S_RTZ: begin
          if (!w_rack) begin
            r_lack0 <= 1'b0;
            r_lack1 <= 1'b0;
            // Hand priority to the other channel so it cannot starve.
            r_prio  <= ~r_sel;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Lack0     = r_lack0;
  assign Lack1     = r_lack1;
  assign Rreq      = r_rreq;
  assign sel       = r_sel;
  assign sample    = r_sample;
  assign retry_cnt = r_retry;
  assign err_fatal = r_fatal;

endmodule
